// File: rtl/osd_diag_conf_ctrl_pkg.sv
// Shared definitions for the diagnosis configuration controller: register map,
// CTRL bit positions, access-size encoding and the commit sequencer states.
package osd_diag_conf_ctrl_pkg;

    localparam logic [15:0] ADDR_NUMWORDS    = 16'h0200;
    localparam logic [15:0] ADDR_CTRL        = 16'h0201;
    localparam logic [15:0] ADDR_CNT         = 16'h0202;
    localparam logic [15:0] ADDR_SHADOW_BASE = 16'h0210;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    localparam logic [1:0] REG_SIZE_16 = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_COPY,
        ST_DONE
    } conf_state_t;

endpackage

// File: rtl/osd_diag_conf_ctrl_if.sv
// OSD register access bus: the host holds reg_request until it sees reg_ack.
interface osd_diag_conf_ctrl_if;
    logic        reg_request;
    logic        reg_write;
    logic [15:0] reg_addr;
    logic [1:0]  reg_size;
    logic [15:0] reg_wdata;
    logic        reg_ack;
    logic        reg_err;
    logic [15:0] reg_rdata;

    modport master (
        output reg_request, reg_write, reg_addr, reg_size, reg_wdata,
        input  reg_ack, reg_err, reg_rdata
    );

    modport slave (
        input  reg_request, reg_write, reg_addr, reg_size, reg_wdata,
        output reg_ack, reg_err, reg_rdata
    );
endinterface

// File: rtl/osd_diag_conf_ctrl_bank.sv
// Shadow and active configuration storage; the active bank is only written
// through the indexed copy port so the core never sees host-side writes directly.
module osd_diag_conf_bank #(
    parameter int NUM_WORDS = 32,
    parameter int IDX_W     = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [15:0]               wr_data,
    input  logic [IDX_W-1:0]          rd_idx,
    output logic [15:0]               rd_data,
    input  logic                      copy_en,
    input  logic [IDX_W-1:0]          copy_idx,
    output logic [16*NUM_WORDS-1:0]   conf_mem
);

    logic [15:0] shadow_reg [NUM_WORDS];
    logic [15:0] active_reg [NUM_WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
        end else begin
            if (clear) begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    shadow_reg[i] <= '0;
                end
            end else if (wr_en) begin
                shadow_reg[wr_idx] <= wr_data;
            end
            if (copy_en) begin
                active_reg[copy_idx] <= shadow_reg[copy_idx];
            end
        end
    end

    assign rd_data = shadow_reg[rd_idx];

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_flat
        assign conf_mem[16*gi +: 16] = active_reg[gi];
    end

endmodule

// File: rtl/osd_diag_conf_ctrl.sv
// Register front end and commit sequencer: waits for the core to idle (or a
// timeout), then copies shadow to active one word per cycle with the core held.
module osd_diag_conf_ctrl
    import osd_diag_conf_ctrl_pkg::*;
#(
    parameter int NUM_WORDS = 32,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    osd_diag_conf_ctrl_if.slave      reg_if,
    input  logic                     core_idle,
    output logic [16*NUM_WORDS-1:0]  conf_mem,
    output logic                     conf_hold,
    output logic                     conf_update,
    output logic                     conf_valid,
    output logic                     busy
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    conf_state_t       state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [15:0]       commit_cnt_reg;
    logic              timeout_flag_reg;
    logic              conf_hold_reg;
    logic              conf_update_reg;
    logic              conf_valid_reg;
    logic              busy_reg;
    logic              ack_reg;
    logic              err_reg;
    logic [15:0]       rdata_reg;

    logic [15:0] shadow_off;
    logic        is_numwords, is_ctrl, is_cnt, is_shadow;
    logic        stall, accept, access_err, do_write;
    logic        shadow_wr, ctrl_wr, clear, commit;
    logic [15:0] shadow_rd_data;
    logic [15:0] rd_mux;

    assign shadow_off  = reg_if.reg_addr - ADDR_SHADOW_BASE;
    assign is_numwords = (reg_if.reg_addr == ADDR_NUMWORDS);
    assign is_ctrl     = (reg_if.reg_addr == ADDR_CTRL);
    assign is_cnt      = (reg_if.reg_addr == ADDR_CNT);
    assign is_shadow   = (shadow_off < 16'(NUM_WORDS));

    // Writes that could disturb the shadow or restart a commit wait for IDLE;
    // the ack cycle itself never accepts, since the host still holds its request.
    assign stall  = busy_reg && reg_if.reg_write && (is_ctrl || is_shadow);
    assign accept = reg_if.reg_request && !ack_reg && !stall;

    assign access_err = (reg_if.reg_size != REG_SIZE_16)
                     || !(is_numwords || is_ctrl || is_cnt || is_shadow)
                     || (reg_if.reg_write && (is_numwords || is_cnt));

    assign do_write  = accept && reg_if.reg_write && !access_err;
    assign shadow_wr = do_write && is_shadow;
    assign ctrl_wr   = do_write && is_ctrl;
    assign clear     = ctrl_wr && reg_if.reg_wdata[CTRL_CLEAR_BIT];
    assign commit    = ctrl_wr && reg_if.reg_wdata[CTRL_COMMIT_BIT];

    always_comb begin
        rd_mux = '0;
        if (is_numwords) begin
            rd_mux = 16'(NUM_WORDS);
        end else if (is_ctrl) begin
            rd_mux = {13'b0, timeout_flag_reg, conf_valid_reg, busy_reg};
        end else if (is_cnt) begin
            rd_mux = commit_cnt_reg;
        end else if (is_shadow) begin
            rd_mux = shadow_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            ack_reg   <= accept;
            err_reg   <= accept && access_err;
            rdata_reg <= (accept && !reg_if.reg_write && !access_err) ? rd_mux : 16'h0000;
        end
    end

    // busy rises with the commit ack; the FSM leaves IDLE on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            idx_reg          <= '0;
            commit_cnt_reg   <= '0;
            timeout_flag_reg <= 1'b0;
            conf_hold_reg    <= 1'b0;
            conf_update_reg  <= 1'b0;
            conf_valid_reg   <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            conf_update_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (busy_reg) begin
                        state_reg        <= ST_WAIT_IDLE;
                        cnt_reg          <= '0;
                        timeout_flag_reg <= 1'b0;
                    end else if (commit) begin
                        busy_reg <= 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (core_idle || (cnt_reg == CNT_W'(TIMEOUT - 1))) begin
                        state_reg     <= ST_COPY;
                        idx_reg       <= '0;
                        conf_hold_reg <= 1'b1;
                        if (!core_idle) begin
                            timeout_flag_reg <= 1'b1;
                        end
                    end
                end
                ST_COPY: begin
                    idx_reg <= idx_reg + 1'b1;
                    if (idx_reg == IDX_W'(NUM_WORDS - 1)) begin
                        state_reg       <= ST_DONE;
                        conf_hold_reg   <= 1'b0;
                        conf_update_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    conf_valid_reg <= 1'b1;
                    commit_cnt_reg <= commit_cnt_reg + 16'd1;
                    busy_reg       <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    osd_diag_conf_bank #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .wr_en    (shadow_wr),
        .wr_idx   (shadow_off[IDX_W-1:0]),
        .wr_data  (reg_if.reg_wdata),
        .rd_idx   (shadow_off[IDX_W-1:0]),
        .rd_data  (shadow_rd_data),
        .copy_en  (state_reg == ST_COPY),
        .copy_idx (idx_reg),
        .conf_mem (conf_mem)
    );

    assign reg_if.reg_ack   = ack_reg;
    assign reg_if.reg_err   = err_reg;
    assign reg_if.reg_rdata = rdata_reg;
    assign conf_hold        = conf_hold_reg;
    assign conf_update      = conf_update_reg;
    assign conf_valid       = conf_valid_reg;
    assign busy             = busy_reg;

endmodule

// File: tb/tb_osd_diag_conf_ctrl.sv
// Bench for osd_diag_conf_ctrl: directed register/commit scenarios plus random
// traffic checked against a word-array model of the shadow/active banks.
module tb_osd_diag_conf_ctrl;
    import osd_diag_conf_ctrl_pkg::*;

    localparam int NW = 32;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_idle = 1'b1;
    logic [16*NW-1:0] conf_mem;
    logic          conf_hold, conf_update, conf_valid, busy;

    osd_diag_conf_ctrl_if bus();

    osd_diag_conf_ctrl #(
        .NUM_WORDS (NW),
        .TIMEOUT   (TO),
        .CNT_W     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reg_if      (bus),
        .core_idle   (core_idle),
        .conf_mem    (conf_mem),
        .conf_hold   (conf_hold),
        .conf_update (conf_update),
        .conf_valid  (conf_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder sampled on the falling edge.
    int   hold_total = 0;
    int   hold_start_cyc = 0;
    int   upd_count = 0;
    int   upd_cyc = 0;
    logic hold_prev = 1'b0;
    always @(negedge clk) begin
        if (conf_hold) hold_total <= hold_total + 1;
        if (conf_hold && !hold_prev) hold_start_cyc <= cyc;
        hold_prev <= conf_hold;
        if (conf_update) begin
            upd_count <= upd_count + 1;
            upd_cyc   <= cyc;
        end
    end

    int vec_cnt = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec_cnt++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model
    logic [15:0] m_shadow [NW];
    logic [15:0] m_active [NW];
    logic [15:0] m_cnt;
    logic        m_valid;
    logic        m_tflag;

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_cnt = '0;
        m_valid = 1'b0;
        m_tflag = 1'b0;
    endtask

    function automatic logic model_err(input logic wr, input logic [15:0] addr, input logic [1:0] size);
        logic known, ro;
        known = (addr == 16'h0200) || (addr == 16'h0201) || (addr == 16'h0202)
             || ((addr >= 16'h0210) && (int'(addr) < 16'h0210 + NW));
        ro = (addr == 16'h0200) || (addr == 16'h0202);
        return (size != REG_SIZE_16) || !known || (wr && ro);
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] addr);
        if (addr == 16'h0200) return 16'(NW);
        if (addr == 16'h0201) return {13'b0, m_tflag, m_valid, 1'b0};
        if (addr == 16'h0202) return m_cnt;
        return m_shadow[int'(addr - 16'h0210)];
    endfunction

    task automatic reg_access(input logic wr, input logic [15:0] addr, input logic [1:0] size,
                              input logic [15:0] wdata, output logic err, output logic [15:0] rdata,
                              output int ack_c, output int lat);
        int n;
        int req_c;
        req_c = cyc;
        err = 1'b1;
        rdata = '0;
        ack_c = -1;
        lat = -1;
        bus.reg_request = 1'b1;
        bus.reg_write   = wr;
        bus.reg_addr    = addr;
        bus.reg_size    = size;
        bus.reg_wdata   = wdata;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.reg_ack && n < 2000);
        if (!bus.reg_ack) begin
            chk("ack_timeout", 32'd0, 32'd1);
            bus.reg_request = 1'b0;
            return;
        end
        ack_c = cyc;
        lat   = ack_c - req_c;
        err   = bus.reg_err;
        rdata = bus.reg_rdata;
        bus.reg_request = 1'b0;
        $display("[%0d] %s addr=0x%04h size=%0d wdata=0x%04h -> err=%0b rdata=0x%04h lat=%0d",
                 cyc, wr ? "WR" : "RD", addr, size, wdata, err, rdata, lat);
        @(posedge clk); #1;
        chk("ack_pulse", {31'b0, bus.reg_ack}, 32'd0);
        chk("rdata_idle", {16'b0, bus.reg_rdata}, 32'd0);
    endtask

    task automatic check_active(input string tag);
        logic [15:0] w;
        for (int i = 0; i < NW; i++) begin
            w = conf_mem[16*i +: 16];
            chk(tag, {16'b0, w}, {16'b0, m_active[i]});
        end
    endtask

    task automatic commit_and_check(input logic [15:0] wdata, input logic idle);
        int h0, u0, ack_c, lat, n, wait_cyc;
        logic e;
        logic [15:0] rd;
        core_idle = idle;
        h0 = hold_total;
        u0 = upd_count;
        reg_access(1'b1, 16'h0201, REG_SIZE_16, wdata, e, rd, ack_c, lat);
        chk("commit_lat", lat, 1);
        chk("commit_err", {31'b0, e}, 32'd0);
        if (wdata[1]) begin
            for (int i = 0; i < NW; i++) m_shadow[i] = '0;
        end
        if (wdata[0]) begin
            for (int i = 0; i < NW; i++) m_active[i] = m_shadow[i];
            m_cnt   = m_cnt + 16'd1;
            m_valid = 1'b1;
            m_tflag = !idle;
            wait_cyc = idle ? 1 : TO;
            n = 0;
            while (upd_count == u0 && n < 2000) begin
                @(posedge clk); #1;
                n++;
            end
            chk("commit_done", upd_count - u0, 1);
            chk("update_latency", upd_cyc - ack_c, wait_cyc + NW + 1);
            chk("hold_start", hold_start_cyc - ack_c, wait_cyc + 1);
            chk("hold_len", hold_total - h0, NW);
            chk("busy_after", {31'b0, busy}, 32'd0);
            chk("valid_after", {31'b0, conf_valid}, 32'd1);
            check_active("active_word");
        end else begin
            chk("no_commit_busy", {31'b0, busy}, 32'd0);
        end
        core_idle = 1'b1;
    endtask

    task automatic access_check(input logic wr, input logic [15:0] addr, input logic [1:0] size,
                                input logic [15:0] wdata, input logic idle);
        logic e_exp, e;
        logic [15:0] rd;
        int ack_c, lat;
        e_exp = model_err(wr, addr, size);
        if (wr && !e_exp && addr == 16'h0201) begin
            commit_and_check(wdata, idle);
            return;
        end
        reg_access(wr, addr, size, wdata, e, rd, ack_c, lat);
        chk("lat", lat, 1);
        chk("err", {31'b0, e}, {31'b0, e_exp});
        if (!e_exp && !wr) chk("rdata", {16'b0, rd}, {16'b0, model_read(addr)});
        if (!e_exp && wr) m_shadow[int'(addr - 16'h0210)] = wdata;
    endtask

    task automatic wait_hold(input string tag);
        int n;
        n = 0;
        while (!conf_hold && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {31'b0, conf_hold}, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        logic [15:0] rd, old_cnt, w;
        int ack_c, lat, u0;
        logic [15:0] wd;
        logic [15:0] ad;
        logic        wr;
        logic [1:0]  sz;
        logic        err_wr   [9] = '{1, 1, 1, 0, 0, 0, 1, 0, 1};
        logic [15:0] err_addr [9] = '{16'h0300, 16'h0200, 16'h0202, 16'h0300, 16'h020F,
                                      16'h0230, 16'h0211, 16'h0201, 16'h0201};
        logic [1:0]  err_size [9] = '{0, 0, 0, 0, 0, 0, 1, 3, 2};

        bus.reg_request = 1'b0;
        bus.reg_write   = 1'b0;
        bus.reg_addr    = '0;
        bus.reg_size    = REG_SIZE_16;
        bus.reg_wdata   = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, bus.reg_ack}, 32'd0);
        chk("rst_err", {31'b0, bus.reg_err}, 32'd0);
        chk("rst_rdata", {16'b0, bus.reg_rdata}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, conf_valid}, 32'd0);
        chk("rst_hold", {31'b0, conf_hold}, 32'd0);
        chk("rst_update", {31'b0, conf_update}, 32'd0);
        chk("rst_conf_mem", {31'b0, conf_mem != '0}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Identification and control readback
        access_check(1'b0, 16'h0200, REG_SIZE_16, 16'h0, 1'b1);
        access_check(1'b0, 16'h0201, REG_SIZE_16, 16'h0, 1'b1);

        // First commit with the core idle
        access_check(1'b1, 16'h0210, REG_SIZE_16, 16'hBEEF, 1'b1);
        access_check(1'b1, 16'h022F, REG_SIZE_16, 16'h1234, 1'b1);
        commit_and_check(16'h0001, 1'b1);
        w = conf_mem[15:0];
        chk("word0_beef", {16'b0, w}, 32'h0000BEEF);
        w = conf_mem[511:496];
        chk("word31_1234", {16'b0, w}, 32'h00001234);
        access_check(1'b0, 16'h0202, REG_SIZE_16, 16'h0, 1'b1);
        access_check(1'b0, 16'h0201, REG_SIZE_16, 16'h0, 1'b1);

        // Timeout path, then the next commit clears the sticky flag
        access_check(1'b1, 16'h0213, REG_SIZE_16, 16'h0F0F, 1'b1);
        commit_and_check(16'h0001, 1'b0);
        access_check(1'b0, 16'h0201, REG_SIZE_16, 16'h0, 1'b1);
        commit_and_check(16'h0001, 1'b1);
        access_check(1'b0, 16'h0201, REG_SIZE_16, 16'h0, 1'b1);

        // Stall of a shadow write during COPY; reads still served at once
        access_check(1'b1, 16'h0215, REG_SIZE_16, 16'h5A5A, 1'b1);
        core_idle = 1'b1;
        u0 = upd_count;
        old_cnt = m_cnt;
        reg_access(1'b1, 16'h0201, REG_SIZE_16, 16'h0001, e, rd, ack_c, lat);
        for (int i = 0; i < NW; i++) m_active[i] = m_shadow[i];
        m_cnt = m_cnt + 16'd1;
        m_valid = 1'b1;
        m_tflag = 1'b0;
        wait_hold("stall_hold");
        reg_access(1'b0, 16'h0202, REG_SIZE_16, 16'h0, e, rd, ack_c, lat);
        chk("copy_read_lat", lat, 1);
        chk("copy_read_cnt", {16'b0, rd}, {16'b0, old_cnt});
        chk("still_copy", {31'b0, conf_hold}, 32'd1);
        reg_access(1'b1, 16'h0215, REG_SIZE_16, 16'hC0DE, e, rd, ack_c, lat);
        chk("stall_done", upd_count - u0, 1);
        chk("stall_ack_cyc", ack_c - upd_cyc, 2);
        chk("stall_err", {31'b0, e}, 32'd0);
        m_shadow[5] = 16'hC0DE;
        check_active("stall_active");
        access_check(1'b0, 16'h0215, REG_SIZE_16, 16'h0, 1'b1);

        // Error responses leave state untouched
        for (int i = 0; i < 9; i++) begin
            access_check(err_wr[i], err_addr[i], err_size[i], 16'hFFFF, 1'b1);
            chk("err_no_busy", {31'b0, busy}, 32'd0);
        end
        access_check(1'b0, 16'h0211, REG_SIZE_16, 16'h0, 1'b1);
        access_check(1'b0, 16'h0215, REG_SIZE_16, 16'h0, 1'b1);
        access_check(1'b0, 16'h0201, REG_SIZE_16, 16'h0, 1'b1);
        access_check(1'b0, 16'h0202, REG_SIZE_16, 16'h0, 1'b1);
        check_active("err_active");

        // Asynchronous reset in the middle of COPY
        access_check(1'b1, 16'h0210, REG_SIZE_16, 16'hA5A5, 1'b1);
        reg_access(1'b1, 16'h0201, REG_SIZE_16, 16'h0001, e, rd, ack_c, lat);
        wait_hold("mid_hold");
        repeat (3) begin @(posedge clk); #1; end
        w = conf_mem[15:0];
        chk("partial_copy", {16'b0, w}, 32'h0000A5A5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_conf_mem", {31'b0, conf_mem != '0}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_valid", {31'b0, conf_valid}, 32'd0);
        chk("arst_hold", {31'b0, conf_hold}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        access_check(1'b0, 16'h0202, REG_SIZE_16, 16'h0, 1'b1);
        access_check(1'b0, 16'h0210, REG_SIZE_16, 16'h0, 1'b1);
        access_check(1'b1, 16'h0210, REG_SIZE_16, 16'h7777, 1'b1);
        access_check(1'b1, 16'h0220, REG_SIZE_16, 16'h8888, 1'b1);
        commit_and_check(16'h0003, 1'b1);
        chk("zero_commit", {31'b0, conf_mem != '0}, 32'd0);
        access_check(1'b0, 16'h0210, REG_SIZE_16, 16'h0, 1'b1);
        access_check(1'b0, 16'h0202, REG_SIZE_16, 16'h0, 1'b1);

        // Random traffic
        for (int it = 0; it < 80; it++) begin
            wd = 16'($urandom);
            if ($urandom_range(0, 9) < 2) begin
                access_check(1'b1, 16'h0201, REG_SIZE_16, wd, $urandom_range(0, 5) != 0);
            end else begin
                wr = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1)
                    ad = 16'h0210 + 16'($urandom_range(0, NW - 1));
                else
                    ad = 16'($urandom_range(16'h01F8, 16'h0240));
                sz = ($urandom_range(0, 7) < 6) ? REG_SIZE_16 : 2'($urandom_range(1, 3));
                access_check(wr, ad, sz, wd, $urandom_range(0, 5) != 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule

// File: doc/osd_diag_conf_ctrl.md
Name: osd_diag_conf_ctrl

Overview:
- Configuration controller for the system diagnosis core. Sits between the OSD register access layer (register request/ack interface, stall-capable) and the diagnosis core's flat configuration vector.
- Host writes event configuration into a shadow bank. A commit request sequences a safe copy into the active bank: it waits for the core to go idle (bounded by a timeout), then copies one word per cycle with the core held.
- Active configuration is never partially updated while the core is evaluating events.

Parameters:
- NUM_WORDS, 32, number of 16-bit configuration words (flits per entry * max events * 2).
- TIMEOUT, 255, maximum cycles WAIT_IDLE waits for core_idle before forcing the copy.
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- reg_request  in  1  register access request; held until reg_ack
- reg_write  in  1  1=write, 0=read
- reg_addr  in  16  register address
- reg_size  in  2  access size; only REG_SIZE_16 is legal
- reg_wdata  in  16  write data
- reg_ack  out  1  access complete, one-cycle pulse
- reg_err  out  1  access error, valid with reg_ack
- reg_rdata  out  16  read data, valid with reg_ack
- core_idle  in  1  diagnosis core has no event evaluation in flight
- conf_mem  out  16*NUM_WORDS  active bank, word i at bits [16i+15:16i]
- conf_hold  out  1  core must ignore conf_mem and its triggers
- conf_update  out  1  one-cycle pulse: new configuration active
- conf_valid  out  1  at least one commit completed since reset
- busy  out  1  FSM not IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - shadow and active banks, commit counter and timeout_flag are all zero.
  - FSM=IDLE; all outputs 0.
- Register map:
  - 0x200 RO: returns NUM_WORDS.
  - 0x201 RW CTRL.
    - Write bit0=1: commit. Write bit1=1: clear shadow (all words 0 in one cycle). Bits 0 and 1 both set: clear happens, then commit of the zeroed shadow.
    - Read: {13'b0, timeout_flag, conf_valid, busy}.
  - 0x202 RO: commit counter, 16 bits, wraps 0xFFFF->0.
  - 0x210..0x210+NUM_WORDS-1 RW: shadow word (addr-0x210).
- Register errors:
  - Any other address, a write to an RO register, or reg_size!=REG_SIZE_16: reg_ack=1 and reg_err=1, with no state change.
- Handshake:
  - Request sampled at cycle N; reg_ack/reg_err/reg_rdata registered and asserted at N+1 for exactly one cycle.
  - No new request is accepted in the ack cycle.
- Stall:
  - While busy=1, writes to 0x201 and to shadow are not acked; they are held until IDLE, then serviced with normal latency.
  - Reads are never stalled.
  - reg_rdata=0 when not acked.
- FSM states: IDLE, WAIT_IDLE, COPY, DONE.
  - IDLE -> WAIT_IDLE: in the cycle the commit write is acked (busy=1 in that cycle). Also clears timeout_flag and loads the timeout counter with 0.
  - WAIT_IDLE -> COPY: when core_idle=1, or when the counter reaches TIMEOUT. On timeout, timeout_flag is set (sticky). The counter increments each WAIT_IDLE cycle.
  - COPY: index 0..NUM_WORDS-1, one word per cycle (active[idx]<=shadow[idx]); conf_hold=1; lasts exactly NUM_WORDS cycles; -> DONE.
  - DONE: one cycle. conf_update=1, conf_valid<=1, counter increments, conf_hold=0. -> IDLE.
- conf_hold timing: asserted from the first COPY cycle through the last COPY cycle. core_idle is ignored once in COPY.
- Commit latency: with core_idle=1 throughout, conf_update appears NUM_WORDS+2 cycles after the commit ack.
- Reset mid-COPY: asynchronous clear; the active bank returns to zero, not to partial contents.
- Shadow writes are only possible in IDLE, so shadow is stable during COPY by construction.

Decomposition:
- Shared package (diagnosis package):
  - Register address constants: ADDR_NUMWORDS, ADDR_CTRL, ADDR_CNT, ADDR_SHADOW_BASE.
  - CTRL bit indices.
  - REG_SIZE_16.
  - FSM state enum typedef.
- Sub-module osd_diag_conf_bank: shadow plus active storage, clear, indexed copy port, flat output. The FSM and register decode stay in the top.

Test Plan:
- Read 0x200 after reset -> ack at N+1, rdata=32, err=0. Read 0x201 -> 0x0000.
- Write 0x210=0xBEEF and 0x22F=0x1234, commit with core_idle=1 -> conf_hold high for 32 cycles; conf_update at ack+34. conf_mem[15:0]=0xBEEF, [511:496]=0x1234. 0x202 reads 1; 0x201 reads 0x0002.
- Commit with core_idle=0 held -> COPY starts after 255 WAIT_IDLE cycles; 0x201 reads 0x0006 after DONE. The next commit clears bit2.
- Shadow write issued during COPY -> no ack until IDLE, then ack one cycle later. Concurrent read of 0x202 during COPY -> acked at N+1.
- Write 0x300, or write 0x200, or reg_size!=REG_SIZE_16 -> ack with err=1, state unchanged.
- rst low asserted mid-COPY -> conf_mem=0, busy=0 and conf_valid=0 immediately. 0x0003 to CTRL then clears shadow and commits zeros.
